// File: rtl/cardinal_dmem_arbiter.sv
// Round-robin arbiter sharing one single-ported data memory between NUM_REQ cores,
// with zero-latency grant and an in-order read-return pipe of depth MEM_LAT.
module cardinal_dmem_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int MEM_LAT = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [0:NUM_REQ-1]          req_en,
    input  logic [0:NUM_REQ-1]          req_wr,
    input  logic [0:NUM_REQ*ADDR_W-1]   req_addr,
    input  logic [0:NUM_REQ*DATA_W-1]   req_wdata,
    output logic [0:NUM_REQ-1]          stall,
    output logic [0:NUM_REQ-1]          rvalid,
    output logic [0:DATA_W-1]           rdata,
    output logic                        mem_en,
    output logic                        mem_wr_en,
    output logic [0:ADDR_W-1]           mem_addr,
    output logic [0:DATA_W-1]           mem_d_out,
    input  logic [0:DATA_W-1]           mem_d_in
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    typedef logic [ID_W-1:0] id_t;

    id_t                r_rr_ptr;
    logic [MEM_LAT-1:0] r_pipe_vld;
    id_t                r_pipe_id [MEM_LAT];

    logic               w_gnt_vld;
    id_t                w_gnt_id;
    logic [ID_W:0]      w_sum;
    id_t                w_idx;
    logic               w_grant;
    logic               w_ret_vld;
    logic [0:ADDR_W-1]  w_addr_arr  [NUM_REQ];
    logic [0:DATA_W-1]  w_wdata_arr [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign w_addr_arr[k]  = req_addr[k*ADDR_W +: ADDR_W];
        assign w_wdata_arr[k] = req_wdata[k*DATA_W +: DATA_W];
    end

    // Priority scan starting at r_rr_ptr, wrapping modulo NUM_REQ.
    // NOTE: blocking assignments here are intentional -- later loop iterations must see
    // w_gnt_vld set by earlier ones; every variable gets a default first so no latch forms.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_id  = '0;
        w_sum     = '0;
        w_idx     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(i);
            if (w_sum >= (ID_W+1)'(NUM_REQ))
                w_sum = w_sum - (ID_W+1)'(NUM_REQ);
            w_idx = w_sum[ID_W-1:0];
            if (!w_gnt_vld && req_en[w_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = w_idx;
            end
        end
    end

    assign w_grant   = w_gnt_vld & ~reset;
    assign w_ret_vld = r_pipe_vld[MEM_LAT-1] & ~reset;

    assign mem_en    = w_grant;
    assign mem_wr_en = w_grant & req_wr[w_gnt_id];
    assign mem_addr  = w_grant ? w_addr_arr[w_gnt_id]  : '0;
    assign mem_d_out = w_grant ? w_wdata_arr[w_gnt_id] : '0;
    assign rdata     = w_ret_vld ? mem_d_in : '0;

    always_comb begin
        stall  = '0;
        rvalid = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            stall[k]  = ~reset & req_en[k] & ~(w_gnt_vld && (w_gnt_id == id_t'(k)));
            rvalid[k] = w_ret_vld & (r_pipe_id[MEM_LAT-1] == id_t'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr   <= '0;
            r_pipe_vld <= '0;
        end else begin
            if (w_gnt_vld)
                r_rr_ptr <= (w_gnt_id == id_t'(NUM_REQ-1)) ? '0 : w_gnt_id + 1'b1;
            r_pipe_vld[0] <= w_gnt_vld & ~req_wr[w_gnt_id];
            for (int s = 1; s < MEM_LAT; s++)
                r_pipe_vld[s] <= r_pipe_vld[s-1];
        end
    end

    // NOTE: the id payload is qualified by r_pipe_vld, so it needs no reset.
    always_ff @(posedge clk) begin
        r_pipe_id[0] <= w_gnt_id;
        for (int s = 1; s < MEM_LAT; s++)
            r_pipe_id[s] <= r_pipe_id[s-1];
    end

endmodule

// File: tb/tb_cardinal_dmem_arbiter.sv
// Bench for cardinal_dmem_arbiter: three instances (MEM_LAT 1..3) driven in parallel,
// directed scenarios plus randomized traffic against a grant-history reference model.
module tb_cardinal_dmem_arbiter;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [0:NR-1]     req_en, req_wr;
    logic [0:NR*AW-1]  req_addr;
    logic [0:NR*DW-1]  req_wdata;
    logic [0:DW-1]     mem_d_in;

    logic [0:NR-1]     stall_o  [1:3];
    logic [0:NR-1]     rvalid_o [1:3];
    logic [0:DW-1]     rdata_o  [1:3];
    logic [0:DW-1]     mdout_o  [1:3];
    logic [0:AW-1]     maddr_o  [1:3];
    logic              mem_en_o [1:3];
    logic              mem_wr_o [1:3];

    for (genvar L = 1; L <= 3; L++) begin : g_dut
        cardinal_dmem_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .req_en    (req_en),
            .req_wr    (req_wr),
            .req_addr  (req_addr),
            .req_wdata (req_wdata),
            .stall     (stall_o[L]),
            .rvalid    (rvalid_o[L]),
            .rdata     (rdata_o[L]),
            .mem_en    (mem_en_o[L]),
            .mem_wr_en (mem_wr_o[L]),
            .mem_addr  (maddr_o[L]),
            .mem_d_out (mdout_o[L]),
            .mem_d_in  (mem_d_in)
        );
    end

    int n_vec = 0;
    int n_err = 0;

    // Reference model: priority pointer, per-cycle history of granted reads, last reset cycle.
    int m_ptr      = 0;
    int m_cyc      = 0;
    int m_last_rst = -1;
    int hist[$];

    int            exp_gnt;
    logic [0:NR-1] exp_stall;
    logic          exp_mem_en, exp_wr;
    logic [0:AW-1] exp_addr;
    logic [0:DW-1] exp_dout;
    logic [0:NR-1] exp_rv [1:3];
    logic [0:DW-1] exp_rd [1:3];

    task automatic model_eval();
        exp_gnt = -1;
        if (reset !== 1'b1) begin
            for (int i = 0; i < NR; i++) begin
                int k;
                k = (m_ptr + i) % NR;
                if (exp_gnt < 0 && req_en[k] === 1'b1) exp_gnt = k;
            end
        end
        for (int k = 0; k < NR; k++)
            exp_stall[k] = (reset !== 1'b1) && (req_en[k] === 1'b1) && (k != exp_gnt);
        exp_mem_en = (exp_gnt >= 0);
        exp_wr     = (exp_gnt >= 0) ? req_wr[exp_gnt] : 1'b0;
        exp_addr   = (exp_gnt >= 0) ? req_addr[exp_gnt*AW +: AW]  : '0;
        exp_dout   = (exp_gnt >= 0) ? req_wdata[exp_gnt*DW +: DW] : '0;
        for (int L = 1; L <= 3; L++) begin
            int src;
            src       = m_cyc - L;
            exp_rv[L] = '0;
            exp_rd[L] = '0;
            if (reset !== 1'b1 && src >= 0 && src > m_last_rst && hist[src] >= 0) begin
                exp_rv[L][hist[src]] = 1'b1;
                exp_rd[L]            = mem_d_in;
            end
        end
    endtask

    // Record this cycle in the model, then advance to the next negedge.
    task automatic tick();
        model_eval();
        if (reset === 1'b1) begin
            m_ptr      = 0;
            m_last_rst = m_cyc;
            hist.push_back(-1);
        end else begin
            hist.push_back((exp_gnt >= 0 && req_wr[exp_gnt] == 1'b0) ? exp_gnt : -1);
            if (exp_gnt >= 0) m_ptr = (exp_gnt + 1) % NR;
        end
        m_cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_quiet();
        req_en    = '0;
        req_wr    = '0;
        req_addr  = '0;
        req_wdata = '0;
        mem_d_in  = '0;
    endtask

    task automatic idle(input int n);
        set_quiet();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        set_quiet();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        req_en   = 4'b1111;
        req_wr   = 4'b0101;
        mem_d_in = 64'hFFFF_0000_FFFF_0000;
        for (int k = 0; k < NR; k++) req_addr[k*AW +: AW] = 32'h1000 + k;
        for (int c = 0; c < 2; c++) begin
            #1;
            for (int L = 1; L <= 3; L++) begin
                n_vec++;
                if ({stall_o[L], rvalid_o[L], mem_en_o[L], mem_wr_o[L]} !== 10'b0) begin
                    n_err++;
                    $display("FAIL reset_ctrl lat%0d: stall=%b rvalid=%b en=%b wr=%b expected all 0",
                             L, stall_o[L], rvalid_o[L], mem_en_o[L], mem_wr_o[L]);
                end
                n_vec++;
                if (maddr_o[L] !== '0 || mdout_o[L] !== '0 || rdata_o[L] !== '0) begin
                    n_err++;
                    $display("FAIL reset_data lat%0d: addr=%h dout=%h rdata=%h expected 0",
                             L, maddr_o[L], mdout_o[L], rdata_o[L]);
                end
            end
            tick();
        end
        reset = 1'b0;
        idle(1);
    endtask

    task automatic test_read();
        do_reset();
        req_en = 4'b1000;
        req_wr = 4'b0000;
        req_addr[0 +: AW] = 32'h10;
        #1;
        n_vec++;
        if (mem_en_o[1] !== 1'b1 || mem_wr_o[1] !== 1'b0 || maddr_o[1] !== 32'h10 || stall_o[1] !== 4'b0000) begin
            n_err++;
            $display("FAIL read_grant: en=%b wr=%b addr=%h stall=%b expected 1 0 00000010 0000",
                     mem_en_o[1], mem_wr_o[1], maddr_o[1], stall_o[1]);
        end
        tick();
        req_en   = 4'b0000;
        mem_d_in = 64'hA5;
        #1;
        n_vec++;
        if (rvalid_o[1] !== 4'b1000 || rdata_o[1] !== 64'hA5) begin
            n_err++;
            $display("FAIL read_return: rvalid=%b rdata=%h expected 1000 a5", rvalid_o[1], rdata_o[1]);
        end
        tick();
        idle(4);
    endtask

    task automatic test_round_robin();
        do_reset();
        req_en = 4'b1111;
        req_wr = 4'b0000;
        for (int k = 0; k < NR; k++) req_addr[k*AW +: AW] = 32'h100 + k;
        for (int i = 0; i < 8; i++) begin
            logic [0:NR-1] es;
            int g;
            g     = i % NR;
            es    = 4'b1111;
            es[g] = 1'b0;
            #1;
            n_vec++;
            if (stall_o[1] !== es || maddr_o[1] !== 32'h100 + g) begin
                n_err++;
                $display("FAIL rr_cycle%0d: stall=%b addr=%h expected %b %h",
                         i, stall_o[1], maddr_o[1], es, 32'h100 + g);
            end
            tick();
        end
        idle(4);
    endtask

    task automatic test_sparse();
        do_reset();
        req_en = 4'b0101;
        req_wr = 4'b0000;
        for (int k = 0; k < NR; k++) req_addr[k*AW +: AW] = 32'h200 + k;
        for (int i = 0; i < 4; i++) begin
            int g;
            g = (i % 2 == 0) ? 1 : 3;
            #1;
            n_vec++;
            if (maddr_o[2] !== 32'h200 + g || stall_o[2] !== ((g == 1) ? 4'b0001 : 4'b0100)) begin
                n_err++;
                $display("FAIL sparse_cycle%0d: addr=%h stall=%b expected grant to core %0d",
                         i, maddr_o[2], stall_o[2], g);
            end
            tick();
        end
        req_en = 4'b1111;
        #1;
        n_vec++;
        if (maddr_o[2] !== 32'h200 || stall_o[2] !== 4'b0111) begin
            n_err++;
            $display("FAIL sparse_wrap: addr=%h stall=%b expected 00000200 0111", maddr_o[2], stall_o[2]);
        end
        tick();
        idle(4);
    endtask

    task automatic test_write();
        req_en = 4'b0010;
        req_wr = 4'b0010;
        req_addr[2*AW +: AW]  = 32'h40;
        req_wdata[2*DW +: DW] = 64'hDEADBEEF_0000_0001;
        #1;
        for (int L = 1; L <= 3; L++) begin
            n_vec++;
            if (mem_en_o[L] !== 1'b1 || mem_wr_o[L] !== 1'b1 || maddr_o[L] !== 32'h40 ||
                mdout_o[L] !== 64'hDEADBEEF_0000_0001) begin
                n_err++;
                $display("FAIL write_issue lat%0d: en=%b wr=%b addr=%h dout=%h expected 1 1 00000040 deadbeef00000001",
                         L, mem_en_o[L], mem_wr_o[L], maddr_o[L], mdout_o[L]);
            end
        end
        tick();
        set_quiet();
        for (int c = 0; c < 5; c++) begin
            mem_d_in = {$urandom, $urandom};
            #1;
            for (int L = 1; L <= 3; L++) begin
                n_vec++;
                if (rvalid_o[L] !== 4'b0000) begin
                    n_err++;
                    $display("FAIL write_no_rvalid lat%0d c%0d: rvalid=%b expected 0000", L, c, rvalid_o[L]);
                end
            end
            tick();
        end
    endtask

    task automatic test_pipelined();
        logic [0:NR-1] seq_en [0:5];
        logic [0:NR-1] seq_rv [0:5];
        seq_en = '{4'b0001, 4'b1000, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
        seq_rv = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b1000, 4'b0010};
        set_quiet();
        for (int k = 0; k < NR; k++) req_addr[k*AW +: AW] = 32'h300 + k;
        for (int c = 0; c < 6; c++) begin
            logic [0:DW-1] er;
            req_en   = seq_en[c];
            mem_d_in = {$urandom, $urandom};
            er       = (seq_rv[c] != 4'b0000) ? mem_d_in : '0;
            #1;
            n_vec++;
            if (rvalid_o[3] !== seq_rv[c] || rdata_o[3] !== er) begin
                n_err++;
                $display("FAIL pipe_lat3 c%0d: rvalid=%b rdata=%h expected %b %h",
                         c, rvalid_o[3], rdata_o[3], seq_rv[c], er);
            end
            tick();
        end
        idle(3);
    endtask

    task automatic test_reset_midflight();
        set_quiet();
        for (int k = 0; k < NR; k++) req_addr[k*AW +: AW] = 32'h400 + k;
        for (int c = 0; c < 6; c++) begin
            req_en   = (c == 0) ? 4'b0100 : 4'b0000;
            reset    = (c == 1);
            mem_d_in = {$urandom, $urandom};
            #1;
            n_vec++;
            if (rvalid_o[2] !== 4'b0000 || rdata_o[2] !== '0) begin
                n_err++;
                $display("FAIL midflight_drop c%0d: rvalid=%b rdata=%h expected 0000 0", c, rvalid_o[2], rdata_o[2]);
            end
            tick();
        end
        req_en = 4'b1111;
        #1;
        n_vec++;
        if (maddr_o[2] !== 32'h400 || stall_o[2] !== 4'b0111) begin
            n_err++;
            $display("FAIL midflight_first: addr=%h stall=%b expected 00000400 0111", maddr_o[2], stall_o[2]);
        end
        tick();
        idle(4);
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            reset  = ($urandom_range(0, 39) == 0);
            req_en = 4'($urandom);
            req_wr = 4'($urandom);
            for (int k = 0; k < NR; k++) begin
                req_addr[k*AW +: AW]  = $urandom;
                req_wdata[k*DW +: DW] = {$urandom, $urandom};
            end
            mem_d_in = {$urandom, $urandom};
            #1;
            model_eval();
            for (int L = 1; L <= 3; L++) begin
                n_vec++;
                if (stall_o[L] !== exp_stall || mem_en_o[L] !== exp_mem_en || mem_wr_o[L] !== exp_wr) begin
                    n_err++;
                    $display("FAIL rand_ctrl n%0d lat%0d: stall=%b en=%b wr=%b expected %b %b %b",
                             n, L, stall_o[L], mem_en_o[L], mem_wr_o[L], exp_stall, exp_mem_en, exp_wr);
                end
                n_vec++;
                if (maddr_o[L] !== exp_addr || mdout_o[L] !== exp_dout) begin
                    n_err++;
                    $display("FAIL rand_mem n%0d lat%0d: addr=%h dout=%h expected %h %h",
                             n, L, maddr_o[L], mdout_o[L], exp_addr, exp_dout);
                end
                n_vec++;
                if (rvalid_o[L] !== exp_rv[L] || rdata_o[L] !== exp_rd[L]) begin
                    n_err++;
                    $display("FAIL rand_ret n%0d lat%0d: rvalid=%b rdata=%h expected %b %h",
                             n, L, rvalid_o[L], rdata_o[L], exp_rv[L], exp_rd[L]);
                end
            end
            tick();
        end
        reset = 1'b0;
        idle(4);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        set_quiet();
        @(negedge clk);
        test_reset();
        test_read();
        test_round_robin();
        test_sparse();
        test_write();
        test_pipelined();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
